// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into HOLD_CYCLES-wide pulses separated by GAP_CYCLES.
// Optional event queue enabled by defining PULSE_QUEUE_EN; otherwise busy-time events are dropped.
module pulse_stretch #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned QW          = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  input  logic          ovf_clr,
  output logic          pulse_out,
  output logic          busy,
  output logic [QW-1:0] pending,
  output logic          overflow
);

  localparam int unsigned MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          final_gap;
  logic          in_busy_slot;
  logic          queue_has;
  logic          drop;

  assign final_gap    = (state == GAP) && (cnt == '0);
  // An event arriving while no launch is possible this cycle
  assign in_busy_slot = pulse_in && ((state == HOLD) || ((state == GAP) && !final_gap));

`ifdef PULSE_QUEUE_EN
  logic q_full;
  assign q_full    = &pending;
  assign queue_has = (pending != '0);
  assign drop      = in_busy_slot && q_full;

  // Final-gap cycles either pass a new event straight through or swap it for a queued one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (in_busy_slot && !q_full) begin
      pending <= pending + QW'(1);
    end else if (final_gap && !pulse_in && queue_has) begin
      pending <= pending - QW'(1);
    end
  end
`else
  assign pending   = '0;
  assign queue_has = 1'b0;
  assign drop      = in_busy_slot;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_in) begin
            state     <= HOLD;
            cnt       <= HOLD_LD;
            pulse_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state     <= GAP;
            cnt       <= GAP_LD;
            pulse_out <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (pulse_in || queue_has) begin
              state     <= HOLD;
              cnt       <= HOLD_LD;
              pulse_out <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky discard flag; a new discard outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
